fir_out_capture: RTL and testbench

Sink-side companion to the `fir` filter: consumes the filter's signed output stream, captures a burst of `DEPTH` consecutive valid samples into an internal flop buffer, and accumulates burst statistics (signed sum and signed peak). After the burst it drains the samples, in order, over a valid/ready read port. It sits between `fir.filter_out` and a slower consumer (bench checker or downstream logic), so filter bursts can be inspected without stalling the filter.

---
 rtl/fir_pkg.sv | 18 +
 rtl/sat_peak_track.sv | 31 +++
 rtl/fir_out_capture.sv | 129 ++++++++++++
 tb/tb_fir_out_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the fir filter and its output-capture sink:
// word size, capture FSM encoding and the burst-sum width helper.
package fir_pkg;

    localparam int FIR_WORD_SIZE = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } cap_state_e;

    // A sum of 'depth' signed words needs log2(depth) guard bits to never overflow.
    function automatic int sum_width(input int word_size, input int depth);
        return word_size + $clog2(depth);
    endfunction

endpackage

// File: rtl/sat_peak_track.sv
// Signed running maximum. 'clr' zeroes the tracker; 'load_first' forces the
// next enabled sample to be taken regardless of the current value.
module sat_peak_track #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         load_first,
    input  logic [W-1:0] din,
    output logic [W-1:0] peak
);

    logic [W-1:0] peak_q;
    logic         take;

    assign take = load_first || ($signed(din) > $signed(peak_q));
    assign peak = peak_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            peak_q <= '0;
        end else if (clr) begin
            peak_q <= '0;
        end else if (en && take) begin
            peak_q <= din;
        end
    end

endmodule

// File: rtl/fir_out_capture.sv
// Captures a DEPTH-sample burst from the fir output, tracks signed sum and
// peak, then drains the burst in order over a valid/ready read port.
module fir_out_capture
    import fir_pkg::*;
#(
    parameter int WORD_SIZE = FIR_WORD_SIZE,
    parameter int DEPTH     = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [WORD_SIZE-1:0]                  sample_in,
    input  logic                                  sample_valid,
    output logic [WORD_SIZE-1:0]                  rd_data,
    output logic                                  rd_valid,
    input  logic                                  rd_ready,
    output logic                                  busy,
    output logic                                  done,
    output logic [sum_width(WORD_SIZE, DEPTH)-1:0] sum,
    output logic [WORD_SIZE-1:0]                  peak
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = sum_width(WORD_SIZE, DEPTH);

    cap_state_e           state_q;
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic [SW-1:0]        sum_q;
    logic [SW-1:0]        sum_d;
    logic                 busy_q;
    logic                 done_q;
    logic                 rd_valid_q;
    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    logic cap_fire;
    logic arm;

    assign arm      = (state_q == ST_IDLE) && start;
    assign cap_fire = (state_q == ST_CAPTURE) && sample_valid;
    assign cnt_d    = cnt_q + CW'(1);
    assign sum_d    = sum_q + {{PW{sample_in[WORD_SIZE-1]}}, sample_in};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_CAPTURE;
                        busy_q   <= 1'b1;
                        wr_ptr_q <= '0;
                        rd_ptr_q <= '0;
                        cnt_q    <= '0;
                        sum_q    <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid) begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        cnt_q    <= cnt_d;
                        sum_q    <= sum_d;
                        // End of burst comes from the count, not pointer wrap.
                        if (cnt_d == CW'(DEPTH)) begin
                            state_q    <= ST_DRAIN;
                            rd_valid_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (rd_ready) begin
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        if (rd_ptr_q == PW'(DEPTH - 1)) begin
                            state_q    <= ST_IDLE;
                            rd_valid_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Buffer holds no reset: contents are only read after being written.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk) begin
                if (cap_fire && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= sample_in;
                end
            end
        end
    endgenerate

    sat_peak_track #(
        .W (WORD_SIZE)
    ) u_peak (
        .clk        (clk),
        .rst        (rst),
        .clr        (arm),
        .en         (cap_fire),
        .load_first (cnt_q == '0),
        .din        (sample_in),
        .peak       (peak)
    );

    assign rd_data  = rd_valid_q ? mem_q[rd_ptr_q] : '0;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;

endmodule

// File: tb/tb_fir_out_capture.sv
// Directed bench for fir_out_capture: inputs driven and outputs checked on the
// falling edge, burst contents and statistics hand-computed per step.
module tb_fir_out_capture;

    logic               clk;
    logic               rst;
    logic               start;
    logic [7:0]         sample_in;
    logic               sample_valid;
    logic [7:0]         rd_data;
    logic               rd_valid;
    logic               rd_ready;
    logic               busy;
    logic               done;
    logic signed [11:0] sum;
    logic [7:0]         peak;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_buf [16];

    fir_out_capture #(
        .WORD_SIZE (8),
        .DEPTH     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .busy         (busy),
        .done         (done),
        .sum          (sum),
        .peak         (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
        $display("[TB] check %-12s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    task automatic chk_idle_reset();
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_rdvalid", 32'(rd_valid), 32'(0));
        chk("rst_rddata", 32'(rd_data), 32'(0));
        chk("rst_sum", 32'($signed(sum)), 32'(0));
        chk("rst_peak", 32'(peak), 32'(0));
    endtask

    // Pulse start from the current falling edge; busy must be high after it.
    task automatic arm_burst();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("arm_busy", 32'(busy), 32'(1));
    endtask

    // Feed exp_buf; with gap set, an idle cycle carrying junk follows each sample.
    task automatic capture(input bit gap, input bit poke_start);
        for (int i = 0; i < 16; i++) begin
            sample_in    = exp_buf[i];
            sample_valid = 1'b1;
            @(negedge clk);
            if (gap) begin
                sample_valid = 1'b0;
                sample_in    = 8'h7F;
                start        = poke_start && (i == 3);
                @(negedge clk);
                start = 1'b0;
                chk("gap_busy", 32'(busy), 32'(1));
            end
        end
        sample_valid = 1'b0;
        sample_in    = 8'h00;
    endtask

    task automatic drain_all(input bit start_on_done);
        for (int i = 0; i < 16; i++) begin
            chk("drn_valid", 32'(rd_valid), 32'(1));
            chk("drn_data", 32'(rd_data), 32'(exp_buf[i]));
            rd_ready = 1'b1;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        chk("end_done", 32'(done), 32'(1));
        chk("end_busy", 32'(busy), 32'(0));
        chk("end_rdvalid", 32'(rd_valid), 32'(0));
        start = start_on_done;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'(0));
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        sample_in    = 8'h00;
        sample_valid = 1'b0;
        rd_ready     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_idle_reset();
        rst = 1'b1;
        // Samples in IDLE must be ignored.
        sample_valid = 1'b1;
        sample_in    = 8'h55;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("idle_busy", 32'(busy), 32'(0));

        // Burst 1: 0,10,...,150; 130..150 read as negative, sum 432, peak 120.
        for (int i = 0; i < 16; i++) exp_buf[i] = 8'(i * 10);
        arm_burst();
        capture(1'b0, 1'b0);
        chk("b1_rdvalid", 32'(rd_valid), 32'(1));
        chk("b1_sum", 32'($signed(sum)), 32'(432));
        chk("b1_peak", 32'(peak), 32'(120));
        drain_all(1'b0);
        chk("b1_sum_hold", 32'($signed(sum)), 32'(432));
        chk("b1_peak_hold", 32'(peak), 32'(120));

        // Burst 2: -8..7 with idle gaps carrying 0x7F, start poked mid-capture.
        for (int i = 0; i < 16; i++) exp_buf[i] = 8'(i - 8);
        arm_burst();
        capture(1'b1, 1'b1);
        chk("b2_sum", 32'($signed(sum)), 32'(-8));
        chk("b2_peak", 32'(peak), 32'(7));
        // Consumer stalls 5 cycles; drain-time samples and a start are ignored.
        for (int h = 0; h < 5; h++) begin
            chk("hold_valid", 32'(rd_valid), 32'(1));
            chk("hold_data", 32'(rd_data), 32'(exp_buf[0]));
            start        = (h == 2);
            sample_valid = 1'b1;
            sample_in    = 8'h7F;
            @(negedge clk);
            start        = 1'b0;
            sample_valid = 1'b0;
        end
        chk("b2_sum_drn", 32'($signed(sum)), 32'(-8));
        drain_all(1'b1);

        // Start coincident with done re-arms: sum cleared, peak reloads to -128.
        chk("rearm_busy", 32'(busy), 32'(1));
        chk("rearm_sum", 32'($signed(sum)), 32'(0));
        chk("rearm_peak", 32'(peak), 32'(0));
        for (int i = 0; i < 16; i++) exp_buf[i] = 8'h80;
        capture(1'b0, 1'b0);
        chk("b3_sum", 32'($signed(sum)), 32'(-2048));
        chk("b3_peak", 32'(peak), 32'(128));
        drain_all(1'b0);

        // Reset after 7 captured samples aborts immediately with no done.
        for (int i = 0; i < 16; i++) exp_buf[i] = 8'(i * 10);
        arm_burst();
        for (int i = 0; i < 7; i++) begin
            sample_in    = exp_buf[i];
            sample_valid = 1'b1;
            @(negedge clk);
        end
        chk("pre_rst_sum", 32'($signed(sum)), 32'(210));
        sample_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_idle_reset();
        @(negedge clk);
        @(negedge clk);
        chk("abort_done", 32'(done), 32'(0));
        rst = 1'b1;
        @(negedge clk);

        // Full burst after abort behaves normally.
        arm_burst();
        capture(1'b0, 1'b0);
        chk("b4_sum", 32'($signed(sum)), 32'(432));
        chk("b4_peak", 32'(peak), 32'(120));
        drain_all(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
